// File: rtl/sha3_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha3_pkg : constants and helpers shared by the SHA-3 padder and perm_blk
// Rev 1.0
// ----------------------------------------------------------------------------
package sha3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAD  = 2'd2,
    ST_CAP  = 2'd3
  } state_e;

  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;
  localparam int         NUM_LANES = 25;

  // Keccak lane index i = x + 5*y, identical to the ordering perm_blk expects
  function automatic logic [4:0] lane_index(input logic [2:0] x, input logic [2:0] y);
    return 5'(x) + (5'(y) * 5'd5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha3_lane_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha3_lane_reg : single-entry lane holding register with push/stop handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module sha3_lane_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_first,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_stop,
  output logic [63:0] out_data,
  output logic        out_first,
  output logic        out_last
);

  logic        valid_q, valid_d;
  logic [63:0] data_q, data_d;
  logic        first_q, first_d;
  logic        last_q, last_d;

  // Ready when empty or when the held lane leaves this cycle, so a reload never bubbles
  assign in_ready = !valid_q || !out_stop;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    first_d = first_q;
    last_d  = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      first_d = in_first;
      last_d  = in_last;
    end else if (valid_q && !out_stop) begin
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 64'h0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_first = first_q;
  assign out_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/sha3_padder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha3_padder : packs message bytes into 64-bit lanes and applies SHA-3 padding
// Rev 1.0
// ----------------------------------------------------------------------------
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic [7:0]  din,
  input  logic        lastin,
  input  logic        emptyin,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic        lastout,
  output logic [63:0] dout
);

  localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0] LAST_LANE = lane_index(3'd4, 3'd4);

  state_e      state_q, state_d;
  logic [4:0]  lane_q, lane_d;
  logic [2:0]  byte_q, byte_d;
  logic [63:0] buf_q, buf_d;
  logic        final_q, final_d;
  logic        extra_q, extra_d;

  logic        w_accept;
  logic        w_ready;
  logic        w_push;
  logic [63:0] w_push_data;
  logic        w_push_first;
  logic        w_push_last;
  logic [5:0]  w_shift;
  logic [5:0]  w_pad_shift;
  logic [63:0] w_ins;
  logic [63:0] w_empty_pad;
  logic [63:0] w_tail_pad;
  logic        w_lane_full;
  logic        w_rate_end;

  // Input is only open in IDLE/FILL and only when a completed lane can be taken
  assign stopin   = (state_q == ST_PAD) || (state_q == ST_CAP) || (pushout && stopout);
  assign w_accept = pushin && !stopin;

  assign w_shift     = {byte_q, 3'b000};
  assign w_pad_shift = {byte_q + 3'd1, 3'b000};
  assign w_ins       = buf_q | (64'(din) << w_shift);
  assign w_empty_pad = buf_q | (64'(PAD_FIRST) << w_shift);
  assign w_tail_pad  = w_ins | (64'(PAD_FIRST) << w_pad_shift);
  assign w_lane_full = (byte_q == 3'd7);
  assign w_rate_end  = w_lane_full && (lane_q == LAST_RATE);

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    byte_d       = byte_q;
    buf_d        = buf_q;
    final_d      = final_q;
    extra_d      = extra_q;
    w_push       = 1'b0;
    w_push_data  = buf_q;
    w_push_first = (lane_q == 5'd0);
    w_push_last  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (w_accept) begin
          if (lastin && emptyin) begin
            buf_d   = w_empty_pad;
            final_d = 1'b1;
            state_d = ST_PAD;
          end else if (w_lane_full) begin
            w_push      = 1'b1;
            w_push_data = w_ins;
            lane_d      = lane_q + 5'd1;
            byte_d      = 3'd0;
            buf_d       = 64'h0;
            if (w_rate_end) begin
              // A last byte that exactly fills the rate owes a whole padding block
              extra_d = lastin;
              state_d = ST_CAP;
            end else if (lastin) begin
              buf_d   = 64'(PAD_FIRST);
              final_d = 1'b1;
              state_d = ST_PAD;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            byte_d = byte_q + 3'd1;
            if (lastin) begin
              buf_d   = w_tail_pad;
              final_d = 1'b1;
              state_d = ST_PAD;
            end else begin
              buf_d   = w_ins;
              state_d = ST_FILL;
            end
          end
        end
      end
      ST_PAD: begin
        if (w_ready) begin
          w_push      = 1'b1;
          w_push_data = (lane_q == LAST_RATE) ? (buf_q ^ {PAD_LAST, 56'h0}) : buf_q;
          buf_d       = 64'h0;
          byte_d      = 3'd0;
          lane_d      = lane_q + 5'd1;
          if (lane_q == LAST_RATE) begin
            state_d = ST_CAP;
          end
        end
      end
      ST_CAP: begin
        if (w_ready) begin
          w_push      = 1'b1;
          w_push_data = 64'h0;
          w_push_last = final_q && (lane_q == LAST_LANE);
          if (lane_q == LAST_LANE) begin
            lane_d = 5'd0;
            if (final_q) begin
              final_d = 1'b0;
              state_d = ST_IDLE;
            end else if (extra_q) begin
              extra_d = 1'b0;
              final_d = 1'b1;
              buf_d   = 64'(PAD_FIRST);
              state_d = ST_PAD;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            lane_d = lane_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= 5'd0;
      byte_q  <= 3'd0;
      buf_q   <= 64'h0;
      final_q <= 1'b0;
      extra_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      byte_q  <= byte_d;
      buf_q   <= buf_d;
      final_q <= final_d;
      extra_q <= extra_d;
    end
  end

  sha3_lane_reg u_lane_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_push),
    .in_ready  (w_ready),
    .in_data   (w_push_data),
    .in_first  (w_push_first),
    .in_last   (w_push_last),
    .out_valid (pushout),
    .out_stop  (stopout),
    .out_data  (dout),
    .out_first (firstout),
    .out_last  (lastout)
  );

endmodule
`default_nettype wire

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 Parameter RATE_LANES, default 17, number of rate lanes per block (17 gives SHA3-256, 136-byte rate); legal range 1..24.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pushin  input  1  upstream byte valid.
REQ-005 stopin  output  1  back-pressure to upstream; a beat transfers when pushin && !stopin.
REQ-006 din  input  8  message byte.
REQ-007 lastin  input  1  beat carries the final message byte.
REQ-008 emptyin  input  1  qualified by lastin; the beat carries no byte (zero-length tail).
REQ-009 pushout  output  1  lane valid toward perm_blk.
REQ-010 stopout  input  1  downstream back-pressure; a lane transfers when pushout && !stopout.
REQ-011 firstout  output  1  marks lane 0 (x0y0) of each block.
REQ-012 lastout  output  1  marks lane 24 of the final block of a message.
REQ-013 dout  output  64  lane data.

Function
REQ-014 Each block is emitted as exactly 25 lanes, in index order i = x + 5*y (i = 0..24). Lanes RATE_LANES..24 are capacity lanes and are always zero.
REQ-015 Bytes pack little-endian: byte k of the rate goes to lane k/8, bits [8*(k%8)+7 : 8*(k%8)].
REQ-016 FSM states and transitions:
- IDLE -> FILL on the first accepted beat.
- FILL: packs bytes.
- FILL -> PAD after the lastin beat.
- PAD: emits the remaining rate lanes, padded.
- CAP: emits the capacity lanes.
- CAP -> IDLE after lane 24 of the final block.
- CAP -> FILL after lane 24 of a non-final block.
REQ-017 Padding for a last byte at rate position p: byte p+1 ^= 0x06 and byte RATE_LANES*8-1 ^= 0x80. If p+1 = R-1, that byte is 0x86.
REQ-018 If the last byte fills the rate exactly (p = R-1), a full extra block follows. Its byte 0 is 0x06, byte R-1 is 0x80, and every other byte is 0.
REQ-019 An emptyin beat places padding at the current byte position, with no data byte.
REQ-020 Latency: a lane appears on dout at the rising edge after its 8th byte is accepted (or after padding completes it).
REQ-021 stopin rules:
- stopin is high in PAD and CAP.
- stopin is high while the output register is occupied and stopout is high.
- stopin is low otherwise.
REQ-022 While pushout && stopout, dout, firstout, lastout and pushout hold stable. No lane is dropped or duplicated.
REQ-023 Byte and lane counters wrap to 0 at block end. A counter never exceeds R-1 bytes or 24 lanes.
REQ-024 A beat with pushin and lastin is accepted only in IDLE or FILL.
REQ-025 A lastin beat at a lane boundary completes that lane and starts padding in the next lane within the same FSM pass.
REQ-026 Simultaneous output transfer and new lane completion: the register reloads in the same cycle, with no bubble.

Reset
REQ-027 On rst, all of the following take effect asynchronously:
- pushout, firstout, lastout = 0; dout = 64'h0; stopin = 0.
- FSM goes to IDLE; byte and lane counters clear.
- A partially packed lane is discarded.
REQ-028 A reset mid-block drops the in-flight block. After release, the next accepted byte starts a new block at lane 0.

Structure
REQ-029 Package sha3_pkg holds the shared constants:
- state enum;
- pad constants 8'h06 and 8'h80;
- NUM_LANES = 25;
- the lane-index helper shared with perm_blk.
REQ-030 One sub-module, sha3_lane_reg, implements the single-entry output holding register with push/stop handshake. It is instantiated once.

Verification
REQ-031 Empty message, i.e. one beat with lastin=1, emptyin=1 -> 25 lanes:
- lane0 = 64'h0000000000000006, with firstout;
- lane16 = 64'h8000000000000000;
- all other lanes 0;
- lastout on lane24.
REQ-032 Bytes 61,62,63 with lastin on 63 -> lane0 = 64'h0000000006636261, lane16 = 64'h8000000000000000, lanes 1-15 and 17-24 = 0.
REQ-033 135 bytes of 0xAA with lastin on byte 134 -> lane16 = 64'h86AAAAAAAAAAAAAA, and a single block is emitted.
REQ-034 136 bytes of 0x00 with lastin on byte 135 -> two blocks, 50 lanes total:
- second block lane0 = 64'h06 and lane16 = 64'h80<<56;
- firstout pulses twice;
- lastout appears only on lane 49.
REQ-035 stopout held high for 10 cycles while lane5 is valid -> dout stays constant for 10 cycles, stopin stays high, and lane sequence 0..24 arrives intact.
REQ-036 rst asserted during lane 9 of a block -> all outputs 0 immediately. The next message's first lane carries firstout, with correct content.
